// File: rtl/regfile_dual.sv
// regfile_dual: 2-write / 4-read integer register file, x0 hardwired to 0.
// Optional same-cycle write bypass: define REGFILE_WRITE_BYPASS_EN.
module regfile_dual #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW1,
  input  logic [ADDR_WIDTH-1:0] RdW1,
  input  logic [DATA_WIDTH-1:0] ResultW1,
  input  logic                  RegWriteW2,
  input  logic [ADDR_WIDTH-1:0] RdW2,
  input  logic [DATA_WIDTH-1:0] ResultW2,
  input  logic [ADDR_WIDTH-1:0] Rs1D1,
  input  logic [ADDR_WIDTH-1:0] Rs2D1,
  input  logic [ADDR_WIDTH-1:0] Rs1D2,
  input  logic [ADDR_WIDTH-1:0] Rs2D2,
  output logic [DATA_WIDTH-1:0] RD1D1,
  output logic [DATA_WIDTH-1:0] RD2D1,
  output logic [DATA_WIDTH-1:0] RD1D2,
  output logic [DATA_WIDTH-1:0] RD2D2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

  logic wen1;
  logic wen2;

  assign wen1 = RegWriteW1 && (RdW1 != '0);
  assign wen2 = RegWriteW2 && (RdW2 != '0);

  // Commit writes; slot 2 is assigned last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wen1) regs[RdW1] <= ResultW1;
      if (wen2) regs[RdW2] <= ResultW2;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] stored(
    input logic [ADDR_WIDTH-1:0] a
  );
    if (a == '0) return '0;
    return regs[a];
  endfunction

`ifdef REGFILE_WRITE_BYPASS_EN
  function automatic logic [DATA_WIDTH-1:0] rdport(
    input logic [ADDR_WIDTH-1:0] a
  );
    if (!rst && wen2 && RdW2 == a) return ResultW2;
    if (!rst && wen1 && RdW1 == a) return ResultW1;
    return stored(a);
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] rdport(
    input logic [ADDR_WIDTH-1:0] a
  );
    return stored(a);
  endfunction
`endif

  // Four independent combinational read ports plus the a0 probe.
  always_comb begin
    RD1D1 = rdport(Rs1D1);
    RD2D1 = rdport(Rs2D1);
    RD1D2 = rdport(Rs1D2);
    RD2D2 = rdport(Rs2D2);
    a0    = stored(A0_IDX);
  end

endmodule

// File: tb/tb_regfile_dual.sv
// tb_regfile_dual: directed vector table plus reset sweep and
// full-address write/read sequences for regfile_dual.
module tb_regfile_dual;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW1;
  logic [4:0]  RdW1;
  logic [31:0] ResultW1;
  logic        RegWriteW2;
  logic [4:0]  RdW2;
  logic [31:0] ResultW2;
  logic [4:0]  Rs1D1, Rs2D1, Rs1D2, Rs2D2;
  logic [31:0] RD1D1, RD2D1, RD1D2, RD2D2, a0;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_dual #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW1(RegWriteW1), .RdW1(RdW1), .ResultW1(ResultW1),
    .RegWriteW2(RegWriteW2), .RdW2(RdW2), .ResultW2(ResultW2),
    .Rs1D1(Rs1D1), .Rs2D1(Rs2D1), .Rs1D2(Rs1D2), .Rs2D2(Rs2D2),
    .RD1D1(RD1D1), .RD2D1(RD2D1), .RD1D2(RD1D2), .RD2D2(RD2D2),
    .a0(a0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        we2;
    logic [4:0]  rd2;
    logic [31:0] d2;
    logic [4:0]  rs [4];
    logic [31:0] ex [4];
    logic [31:0] eb [4];
    logic [31:0] ea;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    input logic r,
    input logic w1, input logic [4:0] a1, input logic [31:0] v1,
    input logic w2, input logic [4:0] a2, input logic [31:0] v2,
    input logic [4:0] s0, input logic [4:0] s1,
    input logic [4:0] s2, input logic [4:0] s3,
    input logic [31:0] x0, input logic [31:0] x1,
    input logic [31:0] x2, input logic [31:0] x3,
    input logic [31:0] b0, input logic [31:0] b1,
    input logic [31:0] b2, input logic [31:0] b3,
    input logic [31:0] ea
  );
    vec_t v;
    v.rst = r;
    v.we1 = w1; v.rd1 = a1; v.d1 = v1;
    v.we2 = w2; v.rd2 = a2; v.d2 = v2;
    v.rs[0] = s0; v.rs[1] = s1; v.rs[2] = s2; v.rs[3] = s3;
    v.ex[0] = x0; v.ex[1] = x1; v.ex[2] = x2; v.ex[3] = x3;
    v.eb[0] = b0; v.eb[1] = b1; v.eb[2] = b2; v.eb[3] = b3;
    v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r,
    input logic w1, input logic [4:0] a1, input logic [31:0] v1,
    input logic w2, input logic [4:0] a2, input logic [31:0] v2);
    rst = r;
    RegWriteW1 = w1; RdW1 = a1; ResultW1 = v1;
    RegWriteW2 = w2; RdW2 = a2; ResultW2 = v2;
  endtask

  task automatic set_rs(input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] s3);
    Rs1D1 = s0; Rs2D1 = s1; Rs1D2 = s2; Rs2D2 = s3;
  endtask

  task automatic chk4(input string nm, input int idx,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] e2, input logic [31:0] e3);
    chk({nm, ".RD1D1"}, idx, RD1D1, e0);
    chk({nm, ".RD2D1"}, idx, RD2D1, e1);
    chk({nm, ".RD1D2"}, idx, RD1D2, e2);
    chk({nm, ".RD2D2"}, idx, RD2D2, e3);
  endtask

  logic [31:0] e [4];
  logic [31:0] pat;

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd0, 5'd0, 5'd0, 5'd0);

    // Reset with write enables asserted: they must be ignored.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd4, 32'hFFFF0000, 1'b1, 5'd6, 32'h0000FFFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Every index on every port reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      set_rs(5'(i), 5'(i), 5'(i), 5'(i));
      #1;
      chk4("rst_sweep", i, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("rst_a0", i, a0, 32'h0);
      @(negedge clk);
    end

    vt[0]  = mk(0, 1,5,32'hDEADBEEF, 1,10,32'h12345678, 5,10,5,10,
                0,0,0,0,
                32'hDEADBEEF,32'h12345678,32'hDEADBEEF,32'h12345678, 0);
    vt[1]  = mk(0, 0,0,0, 0,0,0, 5,0,0,10,
                32'hDEADBEEF,0,0,32'h12345678,
                32'hDEADBEEF,0,0,32'h12345678, 32'h12345678);
    vt[2]  = mk(0, 1,7,32'h11111111, 1,7,32'h22222222, 7,7,7,7,
                0,0,0,0,
                32'h22222222,32'h22222222,32'h22222222,32'h22222222,
                32'h12345678);
    vt[3]  = mk(0, 0,0,0, 0,0,0, 7,5,10,7,
                32'h22222222,32'hDEADBEEF,32'h12345678,32'h22222222,
                32'h22222222,32'hDEADBEEF,32'h12345678,32'h22222222,
                32'h12345678);
    vt[4]  = mk(0, 1,0,32'hFFFFFFFF, 1,0,32'hFFFFFFFF, 0,0,0,0,
                0,0,0,0, 0,0,0,0, 32'h12345678);
    vt[5]  = mk(0, 0,0,0, 0,0,0, 0,0,0,0,
                0,0,0,0, 0,0,0,0, 32'h12345678);
    vt[6]  = mk(0, 1,3,32'hA5A5A5A5, 0,0,0, 5,7,3,10,
                32'hDEADBEEF,32'h22222222,0,32'h12345678,
                32'hDEADBEEF,32'h22222222,32'hA5A5A5A5,32'h12345678,
                32'h12345678);
    vt[7]  = mk(0, 0,0,0, 0,0,0, 3,3,3,3,
                32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,
                32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,
                32'h12345678);
    vt[8]  = mk(1, 1,9,32'h55, 1,3,32'h77, 9,3,5,10,
                0,32'hA5A5A5A5,32'hDEADBEEF,32'h12345678,
                0,32'hA5A5A5A5,32'hDEADBEEF,32'h12345678,
                32'h12345678);
    vt[9]  = mk(0, 0,0,0, 0,0,0, 9,3,5,10,
                0,0,0,0, 0,0,0,0, 0);
    vt[10] = mk(0, 1,9,32'h55, 1,10,32'hCAFEF00D, 9,10,9,10,
                0,0,0,0, 32'h55,32'hCAFEF00D,32'h55,32'hCAFEF00D, 0);
    vt[11] = mk(0, 0,0,0, 0,0,0, 9,10,1,31,
                32'h55,32'hCAFEF00D,0,0,
                32'h55,32'hCAFEF00D,0,0, 32'hCAFEF00D);
    vt[12] = mk(0, 0,1,32'h00000BAD, 1,31,32'h31, 1,31,1,31,
                0,0,0,0, 0,32'h31,0,32'h31, 32'hCAFEF00D);
    vt[13] = mk(0, 0,0,0, 0,0,0, 1,31,9,10,
                0,32'h31,32'h55,32'hCAFEF00D,
                0,32'h31,32'h55,32'hCAFEF00D, 32'hCAFEF00D);

    for (int k = 0; k < 14; k++) begin
      drive(vt[k].rst, vt[k].we1, vt[k].rd1, vt[k].d1,
            vt[k].we2, vt[k].rd2, vt[k].d2);
      set_rs(vt[k].rs[0], vt[k].rs[1], vt[k].rs[2], vt[k].rs[3]);
`ifdef REGFILE_WRITE_BYPASS_EN
      e = vt[k].eb;
`else
      e = vt[k].ex;
`endif
      #1;
      chk4("vec", k, e[0], e[1], e[2], e[3]);
      chk("vec.a0", k, a0, vt[k].ea);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Fill x1..x31 with distinct patterns, odd via slot 1, even via slot 2.
    for (int i = 1; i < 32; i += 2) begin
      pat = 32'h01010101 * 32'(i);
      drive(1'b0, 1'b1, 5'(i), pat,
            (i + 1) < 32, 5'((i + 1) % 32), 32'h01010101 * 32'(i + 1));
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Read back with each port on a different index.
    for (int i = 0; i < 32; i++) begin
      set_rs(5'(i), 5'(31 - i), 5'((i + 7) % 32), 5'((i + 19) % 32));
      #1;
      chk4("fill", i,
           32'h01010101 * 32'(i),
           32'h01010101 * 32'(31 - i),
           32'h01010101 * 32'((i + 7) % 32),
           32'h01010101 * 32'((i + 19) % 32));
      @(negedge clk);
    end
    chk("fill.a0", 10, a0, 32'h0A0A0A0A);

    // Mid-operation reset clears everything on the next edge.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rs(5'd1, 5'd10, 5'd17, 5'd31);
    #1;
    chk4("rst2", 0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst2.a0", 0, a0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dual.md
# regfile_dual

Dual-write, quad-read integer register file for the dual-issue pipeline. It is the consumer of the two writeback results (slot 1 = older instruction, slot 2 = younger) and supplies source operands to both decode slots. Writes commit on the rising clock edge. An optional write-first bypass lets the decode stage see same-cycle writeback results.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- RegWriteW1  input  1  write enable, slot 1 (older)
- RdW1  input  ADDR_WIDTH  destination index, slot 1
- ResultW1  input  DATA_WIDTH  write data, slot 1
- RegWriteW2  input  1  write enable, slot 2 (younger)
- RdW2  input  ADDR_WIDTH  destination index, slot 2
- ResultW2  input  DATA_WIDTH  write data, slot 2
- Rs1D1, Rs2D1  input  ADDR_WIDTH  source indices, decode slot 1
- Rs1D2, Rs2D2  input  ADDR_WIDTH  source indices, decode slot 2
- RD1D1, RD2D1  output  DATA_WIDTH  operand data, decode slot 1
- RD1D2, RD2D2  output  DATA_WIDTH  operand data, decode slot 2
- a0  output  DATA_WIDTH  live contents of register 10, for test observation

## Operation
- Storage covers registers 1..2**ADDR_WIDTH-1. Register 0 has no storage:
  - it reads as 0 on every port, always;
  - writes to it are discarded.
- Write, per slot: on a rising edge with RegWriteWn=1, RdWn≠0 and rst=0, register[RdWn] <= ResultWn.
- Write-write collision (both enables set, RdW1==RdW2≠0): the slot 2 value is stored, because it is the younger instruction. The slot 1 value is dropped.
- Writes to different registers commit independently in the same edge.
- Read ports are combinational, indexed by their own Rs input. The four ports are fully independent; any number may address the same register.
- a0 is the combinational contents of register 10. It never uses bypass.
- Reset: while rst=1 at a rising edge, every stored register becomes 0 and both write enables are ignored.

## Timing
- Write latency is 1 edge: data written at edge N is visible on non-bypassed reads after edge N.
- Read latency is 0 cycles: outputs settle combinationally from the Rs inputs and the stored state.
- Reset values:
  - all registers read 0 one edge after rst is sampled high;
  - a0 = 0 at the same point;
  - outputs before the first reset edge are undefined.
- Reset mid-operation: a write presented in the same cycle as rst=1 is lost. The first write accepted is the one presented in the first cycle with rst=0.
- There is no handshake and no stall input. The block accepts one write per slot every cycle.

## Configuration
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - each read port compares its Rs index with the active writes in the same cycle;
  - if RegWriteW2 && RdW2==Rs && Rs≠0, the port outputs ResultW2;
  - otherwise, if RegWriteW1 && RdW1==Rs && Rs≠0, the port outputs ResultW1;
  - otherwise, the port outputs the stored value.
  - Slot 2 has priority, matching the collision rule. Bypass is suppressed while rst=1. Register 0 still reads 0.
- Undefined: reads return stored state only. A same-cycle write becomes visible after the edge; the hazard unit must cover this case by stalling or forwarding.

## Test plan
- Reset, then read all 32 indices on all four ports -> every port returns 0x00000000; a0=0.
- Write slot 1 x5=0xDEADBEEF and slot 2 x10=0x12345678 in one cycle, then read Rs1D1=5 and Rs2D2=10 the next cycle -> 0xDEADBEEF and 0x12345678; a0=0x12345678.
- Collision: both slots write x7, slot 1 0x11111111 and slot 2 0x22222222 -> x7 reads 0x22222222 afterwards.
- Write x0=0xFFFFFFFF on both slots -> all ports addressing x0 return 0 in that cycle and after.
- Same-cycle read: slot 1 writes x3=0xA5A5A5A5 while Rs1D2=3 -> RD1D2=0xA5A5A5A5 in that cycle with REGFILE_WRITE_BYPASS_EN defined; the old value (0 after reset) without it; 0xA5A5A5A5 in both builds on the next cycle.
- Write x9=0x55 with rst=1 in the same cycle -> x9 reads 0 afterwards. Repeating the write with rst=0 -> x9 reads 0x55.
